// File: rtl/led_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_seq_pkg
// Brief    : Shared types and constants for the LED frame sequencer.
//            This package holds the apa102 command codes, the sequencer
//            state encoding, the RGB pixel struct and the brightness
//            scaling helper.
// Revision : 1.0 - initial release
// ============================================================================
package led_seq_pkg;

  // apa102 command codes
  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_SOF   = 2'b01;
  localparam logic [1:0] CMD_PIXEL = 2'b10;
  localparam logic [1:0] CMD_EOF   = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SOF   = 3'd1,
    FETCH = 3'd2,
    PIXEL = 3'd3,
    EOF   = 3'd4,
    DONE  = 3'd5
  } seq_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb8_t;

  // (c * (dim+1)) >> 8. The product always fits in 16 bits (255*256).
  function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] dim);
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, dim} + 16'd1);
    return p[15:8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : frame_tick_gen
// Brief    : Free-running frame-period counter. tick is high for one cycle
//            whenever the counter sits at FRAME_DIV-1.
// Revision : 1.0 - initial release
// ============================================================================
module frame_tick_gen #(
  parameter int FRAME_DIV = 200000,
  parameter int CW        = 18
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam logic [CW-1:0] C_LAST = CW'(FRAME_DIV - 1);

  logic [CW-1:0] r_count;

  // Count 0..FRAME_DIV-1 and wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (r_count == C_LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign tick = (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/led_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : led_frame_sequencer
// Brief    : Once per frame tick this block issues SOF, N_PIXELS PIXEL
//            commands and EOF to the apa102 driver. Colours are fetched
//            through an indexed req/valid handshake.
//            Optional macro LED_DIM_EN scales each channel by (dim+1)/256.
// Revision : 1.0 - initial release
// ============================================================================
module led_frame_sequencer
  import led_seq_pkg::*;
#(
  parameter int N_PIXELS  = 300,
  parameter int FRAME_DIV = 200000,
  parameter int CW        = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        px_req,
  output logic [15:0] px_index,
  input  logic        px_valid,
  input  logic [7:0]  src_red,
  input  logic [7:0]  src_green,
  input  logic [7:0]  src_blue,
  input  logic [7:0]  dim,
  output logic [1:0]  apa_cmd,
  output logic        apa_strobe,
  input  logic        apa_busy,
  output logic [7:0]  pixel_red,
  output logic [7:0]  pixel_green,
  output logic [7:0]  pixel_blue,
  output logic        frame_done,
  output logic        overrun
);

  localparam logic [15:0] C_LAST_PX = 16'(N_PIXELS - 1);

  seq_state_t  r_state, w_state;
  logic [1:0]  r_cmd, w_cmd;
  logic        r_strobe, w_strobe;
  logic        r_req, w_req;
  logic        r_done, w_done;
  logic        r_ovr, w_ovr;
  logic [15:0] r_index, w_index;
  rgb8_t       r_pix, w_pix;
  rgb8_t       w_src;
  logic        w_tick;
  logic        w_issue;

  frame_tick_gen #(
    .FRAME_DIV (FRAME_DIV),
    .CW        (CW)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

`ifdef LED_DIM_EN
  assign w_src.r = scale8(src_red,   dim);
  assign w_src.g = scale8(src_green, dim);
  assign w_src.b = scale8(src_blue,  dim);
`else
  assign w_src.r = src_red;
  assign w_src.g = src_green;
  assign w_src.b = src_blue;
  // dim is kept on the port so both builds share one interface
  logic w_unused_dim;
  assign w_unused_dim = ^dim;
`endif

  // A command may only go out when the driver is idle and no strobe is in flight
  assign w_issue = !apa_busy && !r_strobe;

  // Next-state and next-output logic. apa_cmd is always updated at least one
  // edge before the strobe that uses it.
  always_comb begin
    w_state  = r_state;
    w_cmd    = r_cmd;
    w_strobe = 1'b0;
    w_req    = r_req;
    w_index  = r_index;
    w_pix    = r_pix;
    w_done   = 1'b0;
    w_ovr    = r_ovr | (w_tick && (r_state != IDLE));
    case (r_state)
      IDLE: begin
        if (w_tick && enable) begin
          w_state = SOF;
          w_cmd   = CMD_SOF;
        end
      end
      SOF: begin
        if (w_issue) begin
          w_strobe = 1'b1;
          w_index  = '0;
          w_req    = 1'b1;
          w_state  = FETCH;
        end
      end
      FETCH: begin
        if (px_valid) begin
          w_pix   = w_src;
          w_req   = 1'b0;
          w_cmd   = CMD_PIXEL;
          w_state = PIXEL;
        end
      end
      PIXEL: begin
        if (w_issue) begin
          w_strobe = 1'b1;
          if (r_index == C_LAST_PX) begin
            w_state = EOF;
          end else begin
            w_index = r_index + 16'd1;
            w_req   = 1'b1;
            w_state = FETCH;
          end
        end
      end
      EOF: begin
        // First EOF cycle still carries the last PIXEL strobe, so the
        // command switches here and the strobe follows on a later cycle.
        w_cmd = CMD_EOF;
        if (w_issue && (r_cmd == CMD_EOF)) begin
          w_strobe = 1'b1;
          w_state  = DONE;
        end
      end
      DONE: begin
        w_done  = 1'b1;
        w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cmd    <= CMD_NONE;
      r_strobe <= 1'b0;
      r_req    <= 1'b0;
      r_done   <= 1'b0;
      r_ovr    <= 1'b0;
      r_index  <= '0;
      r_pix    <= '0;
    end else begin
      r_state  <= w_state;
      r_cmd    <= w_cmd;
      r_strobe <= w_strobe;
      r_req    <= w_req;
      r_done   <= w_done;
      r_ovr    <= w_ovr;
      r_index  <= w_index;
      r_pix    <= w_pix;
    end
  end

  assign px_req      = r_req;
  assign px_index    = r_index;
  assign apa_cmd     = r_cmd;
  assign apa_strobe  = r_strobe;
  assign pixel_red   = r_pix.r;
  assign pixel_green = r_pix.g;
  assign pixel_blue  = r_pix.b;
  assign frame_done  = r_done;
  assign overrun     = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_led_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_frame_sequencer
// Brief    : Directed self-checking bench for led_frame_sequencer. A main
//            instance (4 pixels, 1000-cycle frame) covers the frame sequence,
//            busy hold-off, slow source, dimming, enable and reset. A second
//            instance (4 pixels, 10-cycle frame) covers overrun.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_frame_sequencer;
  import led_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- main instance ----------------
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        px_valid = 1'b0;
  logic        apa_busy = 1'b0;
  logic [7:0]  src_red = 8'd0, src_green = 8'd0, src_blue = 8'd0, dim = 8'd255;
  logic        px_req, apa_strobe, frame_done, overrun;
  logic [15:0] px_index;
  logic [1:0]  apa_cmd;
  logic [7:0]  pixel_red, pixel_green, pixel_blue;

  led_frame_sequencer #(.N_PIXELS(4), .FRAME_DIV(1000), .CW(10)) dut (
    .clk(clk), .rst(rst), .enable(enable), .px_req(px_req), .px_index(px_index),
    .px_valid(px_valid), .src_red(src_red), .src_green(src_green), .src_blue(src_blue),
    .dim(dim), .apa_cmd(apa_cmd), .apa_strobe(apa_strobe), .apa_busy(apa_busy),
    .pixel_red(pixel_red), .pixel_green(pixel_green), .pixel_blue(pixel_blue),
    .frame_done(frame_done), .overrun(overrun)
  );

  // ---------------- overrun instance ----------------
  logic        o_rst = 1'b1;
  logic        o_px_valid = 1'b0;
  logic        o_apa_busy = 1'b0;
  logic [7:0]  o_src_red = 8'd0, o_src_green = 8'd0, o_src_blue = 8'd0;
  logic        o_px_req, o_apa_strobe, o_frame_done, o_overrun;
  logic [15:0] o_px_index;
  logic [1:0]  o_apa_cmd;
  logic [7:0]  o_pixel_red, o_pixel_green, o_pixel_blue;

  led_frame_sequencer #(.N_PIXELS(4), .FRAME_DIV(10), .CW(4)) dut_o (
    .clk(clk), .rst(o_rst), .enable(1'b1), .px_req(o_px_req), .px_index(o_px_index),
    .px_valid(o_px_valid), .src_red(o_src_red), .src_green(o_src_green), .src_blue(o_src_blue),
    .dim(8'd255), .apa_cmd(o_apa_cmd), .apa_strobe(o_apa_strobe), .apa_busy(o_apa_busy),
    .pixel_red(o_pixel_red), .pixel_green(o_pixel_green), .pixel_blue(o_pixel_blue),
    .frame_done(o_frame_done), .overrun(o_overrun)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_cmd(input int k);
    if (k == 0) return 1;
    if (k == 5) return 3;
    return 2;
  endfunction

  // ---------------- main-instance models and monitor ----------------
  int n;                          // cycle number since reset release
  int bcnt, scnt;
  int sof_hold = 3;
  int slow_idx = 65535;
  int slow_lat = 1;
  int dim_mode = 0;
  int s_cmd[$], s_red[$], s_grn[$], s_cyc[$];
  int stab_err = 0, fd_cnt = 0;
  int req2_cyc = 0, last_req2 = 0, strb_in_req2 = 0;
  logic [1:0] p_cmd;
  logic [7:0] p_red, p_grn, p_blu;

  always @(negedge clk) begin
    if (rst) begin
      n = -1; bcnt = 0; scnt = 0; px_valid = 1'b0; apa_busy = 1'b0;
    end else begin
      n = n + 1;
      if (apa_strobe) begin
        s_cmd.push_back(int'(apa_cmd));
        s_red.push_back(int'(pixel_red));
        s_grn.push_back(int'(pixel_green));
        s_cyc.push_back(n);
        if (apa_cmd !== p_cmd || pixel_red !== p_red || pixel_green !== p_grn || pixel_blue !== p_blu)
          stab_err++;
      end
      if (frame_done) fd_cnt++;
      if (px_req && px_index == 16'd2) begin
        req2_cyc++;
        last_req2 = n;
        if (apa_strobe) strb_in_req2++;
      end
      p_cmd = apa_cmd; p_red = pixel_red; p_grn = pixel_green; p_blu = pixel_blue;
      // apa102 busy model
      if (apa_strobe) bcnt = (apa_cmd == CMD_SOF) ? sof_hold : 3;
      else if (bcnt > 0) bcnt--;
      apa_busy = (bcnt > 0);
      // pixel source model
      px_valid = 1'b0;
      if (px_req) begin
        if (scnt >= ((int'(px_index) == slow_idx) ? slow_lat : 1)) begin
          px_valid = 1'b1;
          if (dim_mode != 0) begin
            src_red = 8'd200; src_green = 8'd200; src_blue = 8'd200;
            case (px_index[1:0])
              2'd0:    dim = 8'd127;
              2'd2:    dim = 8'd0;
              default: dim = 8'd255;
            endcase
          end else begin
            src_red   = {px_index[3:0], 4'h0};
            src_green = {px_index[3:0], 4'h1};
            src_blue  = {px_index[3:0], 4'h2};
            dim       = 8'd255;
          end
        end else begin
          scnt++;
        end
      end else begin
        scnt = 0;
      end
    end
  end

  // ---------------- overrun-instance models and monitor ----------------
  int on, obcnt, oscnt;
  int o_strobes = 0, o_pat_err = 0, o_frames = 0;
  int o_sof_first = -1, o_ovr_first = -1;

  always @(negedge clk) begin
    if (o_rst) begin
      on = -1; obcnt = 0; oscnt = 0; o_px_valid = 1'b0; o_apa_busy = 1'b0;
    end else begin
      on = on + 1;
      if (o_apa_strobe) begin
        if (o_strobes == 0) o_sof_first = on;
        if (int'(o_apa_cmd) != exp_cmd(o_strobes % 6)) o_pat_err++;
        o_strobes++;
      end
      if (o_frame_done) o_frames++;
      if (o_overrun && o_ovr_first < 0) o_ovr_first = on;
      if (o_apa_strobe) obcnt = 3;
      else if (obcnt > 0) obcnt--;
      o_apa_busy = (obcnt > 0);
      o_px_valid = 1'b0;
      if (o_px_req) begin
        if (oscnt >= 1) begin
          o_px_valid  = 1'b1;
          o_src_red   = {o_px_index[3:0], 4'h0};
          o_src_green = o_src_red;
          o_src_blue  = o_src_red;
        end else begin
          oscnt++;
        end
      end else begin
        oscnt = 0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic clear_log();
    s_cmd.delete(); s_red.delete(); s_grn.delete(); s_cyc.delete();
    stab_err = 0; fd_cnt = 0; req2_cyc = 0; last_req2 = 0; strb_in_req2 = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int seen;
    seen = 0;
    for (int i = 0; i < budget && seen == 0; i++) begin
      step();
      if (frame_done) seen = 1;
    end
    check(tag, seen, 1);
  endtask

  task automatic check_sequence(input string tag);
    check({tag, "_count"}, s_cmd.size(), 6);
    for (int k = 0; k < 6; k++)
      check($sformatf("%s_cmd%0d", tag, k), s_cmd[k], exp_cmd(k));
    check({tag, "_stable"}, stab_err, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int found;
    int exp_dim[4];
`ifdef LED_DIM_EN
    exp_dim = '{100, 200, 0, 200};
`else
    exp_dim = '{200, 200, 200, 200};
`endif

    repeat (3) step();
    check("rst_cmd",    int'(apa_cmd), 0);
    check("rst_strobe", int'(apa_strobe), 0);
    check("rst_req",    int'(px_req), 0);
    check("rst_index",  int'(px_index), 0);
    check("rst_red",    int'(pixel_red), 0);
    check("rst_done",   int'(frame_done), 0);
    check("rst_ovr",    int'(overrun), 0);
    rst = 1'b0;
    clear_log();

    // Basic frame: busy 3, latency 1, colour = index*16
    wait_done("f1_done", 1200);
    check_sequence("f1");
    check("f1_sof_cyc", s_cyc[0], 1001);
    for (int k = 1; k < 5; k++)
      check($sformatf("f1_red%0d", k - 1), s_red[k], (k - 1) * 16);
    check("f1_green2", s_grn[3], 33);
    step();
    check("f1_fd_pulses", fd_cnt, 1);
    check("f1_ovr", int'(overrun), 0);

    // Busy hold-off of 50 cycles after SOF
    sof_hold = 50;
    clear_log();
    wait_done("f2_done", 1200);
    check_sequence("f2");
    check("f2_sof_cyc", s_cyc[0], 2001);
    check("f2_holdoff", s_cyc[1] - s_cyc[0], 51);

    // Slow source: index 2 answers after 20 cycles
    sof_hold = 3;
    slow_idx = 2;
    slow_lat = 20;
    clear_log();
    wait_done("f3_done", 1200);
    check_sequence("f3");
    check("f3_req2_cycles", req2_cyc, 21);
    check("f3_strobes_in_fetch2", strb_in_req2, 1);
    check("f3_px2_after_data", s_cyc[3] - last_req2, 2);
    check("f3_red2", s_red[3], 32);

    // Dimming: colour 200 with dim 127/255/0/255
    slow_idx = 65535;
    dim_mode = 1;
    clear_log();
    wait_done("f4_done", 1200);
    check_sequence("f4");
    for (int k = 0; k < 4; k++)
      check($sformatf("f4_dim_red%0d", k), s_red[k + 1], exp_dim[k]);
    dim_mode = 0;

    // Enable dropped just after SOF: frame completes, no further frame
    clear_log();
    found = 0;
    for (int i = 0; i < 1100 && found == 0; i++) begin
      step();
      if (apa_strobe) found = 1;
    end
    check("f5_sof_seen", found, 1);
    enable = 1'b0;
    wait_done("f5_done", 200);
    check_sequence("f5");
    check("f5_sof_cyc", s_cyc[0], 5001);
    clear_log();
    repeat (1100) step();
    check("f5_no_new_frame", s_cmd.size(), 0);

    // Reset during FETCH of index 1
    enable = 1'b1;
    found = 0;
    for (int i = 0; i < 1100 && found == 0; i++) begin
      step();
      if (px_req && px_index == 16'd1) found = 1;
    end
    check("rst_mid_found", found, 1);
    rst = 1'b1;
    step();
    check("rstm_strobe", int'(apa_strobe), 0);
    check("rstm_cmd",    int'(apa_cmd), 0);
    check("rstm_req",    int'(px_req), 0);
    check("rstm_index",  int'(px_index), 0);
    check("rstm_green",  int'(pixel_green), 0);
    rst = 1'b0;
    clear_log();
    found = 0;
    for (int i = 0; i < 1100 && found == 0; i++) begin
      step();
      if (s_cmd.size() > 0) found = 1;
    end
    check("rstm_restart", found, 1);
    check("rstm_first_cmd", s_cmd[0], 1);
    check("rstm_sof_cyc", s_cyc[0], 1001);

    // Overrun instance: 10-cycle frame period
    o_rst = 1'b0;
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      step();
      if (o_frames >= 3) found = 1;
    end
    check("ovr_three_frames", found, 1);
    check("ovr_sof_cyc", o_sof_first, 11);
    check("ovr_first_set", o_ovr_first, 20);
    check("ovr_strobes", o_strobes, 18);
    check("ovr_pattern", o_pat_err, 0);
    check("ovr_sticky", int'(o_overrun), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
